square_wave_generator: RTL and testbench

Consumes the `halfPeriod` code from `wave_period_calculator` and produces the audible square wave. The output toggles every `halfPeriod` clock cycles, and `halfPeriod == 0` means silence. A new period is adopted only at a half-cycle boundary, so key changes never produce runt pulses. The block sits between the key/period logic and the audio output pin.

---
 rtl/square_wave_generator.sv | 95 +++++++++
 tb/tb_square_wave_generator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_generator.sv
// Square-wave tone generator: toggles wave every curHalf clocks, halfPeriod == 0 means silence.
// Optional macro SQUARE_WAVE_IMMEDIATE_STOP_EN: stop on the first edge that samples halfPeriod == 0.
module square_wave_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] halfPeriod,
  output logic             wave,
  output logic             edgePulse,
  output logic             active
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] cur_half, cur_half_nxt;
  logic             wave_nxt, pulse_nxt;
  logic             terminal;
  logic             stop_now;

  // cur_half is never 0 in RUN, so the decrement cannot wrap there
  assign terminal = (count == (cur_half - WIDTH'(1)));

`ifdef SQUARE_WAVE_IMMEDIATE_STOP_EN
  assign stop_now = (halfPeriod == '0);
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      cur_half  <= '0;
      wave      <= 1'b0;
      edgePulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      cur_half  <= cur_half_nxt;
      wave      <= wave_nxt;
      edgePulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    cur_half_nxt = cur_half;
    wave_nxt     = wave;
    pulse_nxt    = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        wave_nxt  = 1'b0;
        if (halfPeriod != '0) begin
          cur_half_nxt = halfPeriod;
          wave_nxt     = 1'b1;
          pulse_nxt    = 1'b1;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (stop_now) begin
          state_nxt = IDLE;
          count_nxt = '0;
          wave_nxt  = 1'b0;
          pulse_nxt = wave;
        end else if (terminal) begin
          count_nxt    = '0;
          cur_half_nxt = halfPeriod;
          if (halfPeriod != '0) begin
            wave_nxt  = ~wave;
            pulse_nxt = 1'b1;
          end else begin
            wave_nxt  = 1'b0;
            pulse_nxt = wave;
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active = (state == RUN);

endmodule

// File: tb/tb_square_wave_generator.sv
// Self-checking bench for square_wave_generator: directed scenarios plus randomized
// stimulus compared against a boundary-time reference model.
module tb_square_wave_generator;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] hp  = '0;
  logic         wave, epulse, active;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  square_wave_generator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .halfPeriod(hp),
    .wave      (wave),
    .edgePulse (epulse),
    .active    (active)
  );

  // Reference model: tracks the absolute cycle at which the current half ends.
  int   cyc   = 0;
  int   m_bnd = 0;
  logic m_run = 1'b0, m_wave = 1'b0, m_edge = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 1'b0; m_wave = 1'b0; m_edge = 1'b0;
    end else begin
      cyc++;
      if (!m_run) begin
        m_edge = 1'b0;
        m_wave = 1'b0;
        if (hp != 0) begin
          m_run = 1'b1; m_wave = 1'b1; m_edge = 1'b1; m_bnd = cyc + int'(hp);
        end
      end
`ifdef SQUARE_WAVE_IMMEDIATE_STOP_EN
      else if (hp == 0) begin
        m_edge = m_wave; m_wave = 1'b0; m_run = 1'b0;
      end
`endif
      else if (cyc == m_bnd) begin
        if (hp != 0) begin
          m_edge = 1'b1; m_wave = ~m_wave; m_bnd = cyc + int'(hp);
        end else begin
          m_edge = m_wave; m_wave = 1'b0; m_run = 1'b0;
        end
      end else begin
        m_edge = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits until the model is in a high half with k cycles left before its boundary.
  task automatic wait_phase(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (m_run && m_wave && (m_bnd - cyc) == k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hp = 8'd92;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({wave, epulse, active} !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold: got %b expected 000", {wave, epulse, active});
      end
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({wave, epulse, active} !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_start: got %b expected 111", {wave, epulse, active});
    end
  endtask

  task automatic test_steady();
    int   last = -1;
    logic prev = wave;
    hp = 8'd92;
    for (int i = 0; i < 1000; i++) begin
      tick();
      tests++;
      if ({wave, epulse, active} !== {m_wave, m_edge, m_run}) begin
        fails++;
        $display("FAIL steady_model cyc=%0d: got %b expected %b", cyc, {wave, epulse, active}, {m_wave, m_edge, m_run});
      end
      tests++;
      if (epulse !== (wave ^ prev)) begin
        fails++;
        $display("FAIL steady_pulse_per_toggle cyc=%0d: pulse %b toggle %b", cyc, epulse, wave ^ prev);
      end
      prev = wave;
      if (epulse === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (cyc - last != 92) begin
            fails++;
            $display("FAIL steady_half_len: got %0d expected 92", cyc - last);
          end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_boundary_change();
    bit ok;
    int n;
    int exp_len [3] = '{52, 61, 61};
    hp = 8'd92;
    wait_phase(52, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL change_reach_count40: got timeout expected phase reached");
    end
    hp = 8'd61;
    for (int h = 0; h < 3; h++) begin
      n = 0;
      do begin tick(); n++; end while (epulse !== 1'b1 && n < 300);
      tests++;
      if (n != exp_len[h]) begin
        fails++;
        $display("FAIL change_half%0d_len: got %0d expected %0d", h, n, exp_len[h]);
      end
    end
  endtask

  task automatic test_stop();
    bit ok;
    int n = 0;
    hp = 8'd92;
    wait_phase(82, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stop_reach_count10: got timeout expected phase reached");
    end
    hp = 8'd0;
    do begin tick(); n++; end while (wave !== 1'b0 && n < 300);
`ifdef SQUARE_WAVE_IMMEDIATE_STOP_EN
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL stop_latency: got %0d expected 1", n);
    end
`else
    tests++;
    if (n != 82) begin
      fails++;
      $display("FAIL stop_latency: got %0d expected 82", n);
    end
`endif
    tests++;
    if ({epulse, active} !== 2'b10) begin
      fails++;
      $display("FAIL stop_final_edge: got %b expected 10", {epulse, active});
    end
    repeat (5) begin
      tick();
      tests++;
      if ({wave, epulse, active} !== 3'b000) begin
        fails++;
        $display("FAIL stop_idle: got %b expected 000", {wave, epulse, active});
      end
    end
  endtask

  task automatic test_min_period();
    logic prev;
    int   n;
    hp = 8'd1;
    tick();
    prev = wave;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (epulse !== 1'b1 || wave !== ~prev) begin
        fails++;
        $display("FAIL min_toggle: got wave %b pulse %b expected wave %b pulse 1", wave, epulse, ~prev);
      end
      prev = wave;
    end
    hp = 8'd255;
    tick();
    for (int h = 0; h < 2; h++) begin
      n = 0;
      do begin tick(); n++; end while (epulse !== 1'b1 && n < 600);
      tests++;
      if (n != 255) begin
        fails++;
        $display("FAIL max_half_len: got %0d expected 255", n);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n = 0;
    hp = 8'd92;
    wait_phase(42, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL areset_reach_count50: got timeout expected phase reached");
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({wave, epulse, active} !== 3'b000) begin
      fails++;
      $display("FAIL areset_immediate: got %b expected 000", {wave, epulse, active});
    end
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({wave, epulse, active} !== 3'b111) begin
      fails++;
      $display("FAIL areset_restart: got %b expected 111", {wave, epulse, active});
    end
    do begin tick(); n++; end while (epulse !== 1'b1 && n < 300);
    tests++;
    if (n != 92) begin
      fails++;
      $display("FAIL areset_fresh_half: got %0d expected 92", n);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin
        r = int'($urandom_range(3));
        if (r == 0)      hp = 8'd0;
        else if (r == 3) hp = 8'($urandom_range(40, 1));
        else             hp = 8'($urandom_range(4, 1));
      end
      tick();
      tests++;
      if ({wave, epulse, active} !== {m_wave, m_edge, m_run}) begin
        fails++;
        $display("FAIL random_model cyc=%0d hp=%0d: got %b expected %b", cyc, hp, {wave, epulse, active}, {m_wave, m_edge, m_run});
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_boundary_change();
    test_stop();
    test_min_period();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
